// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the sizing rule for the bit counter.
package serial_subtractor_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit-counter width: enough to count WIDTH bits, never narrower than 1.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle of the serial subtractor; the master issues
// operands and start, the slave returns the difference and status.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_restador.sv
// 1-bit full-subtractor cell: r = a - b - cin, cout is the borrow out.
module restador (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic r,
    output logic cout
);

    // Difference bit and borrow for one bit position.
    always_comb begin
        r    = a ^ b ^ cin;
        cout = (~a & b) | (~a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a single restador cell and a borrow flop.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_subtractor_if.slave bus
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic [WIDTH-1:0] res_nxt_s;
    logic [WIDTH-1:0] diff_r;
    logic [CW-1:0]    cnt_r;
    logic             brw_r;
    logic             bout_r;
    logic             busy_r;
    logic             done_r;
    logic             r_s;
    logic             cout_s;

    restador u_cell (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (brw_r),
        .r    (r_s),
        .cout (cout_s)
    );

    // Result register with this cycle's difference bit entering at the MSB.
    always_comb begin
        res_nxt_s          = res_sh_r >> 1'b1;
        res_nxt_s[WIDTH-1] = r_s;
    end

    // FSM, operand shifters, borrow flop, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {WIDTH{1'b0}};
            diff_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            brw_r    <= 1'b0;
            bout_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    // DONE accepts start too, giving back-to-back operation.
                    if (bus.start) begin
                        a_sh_r   <= bus.a;
                        b_sh_r   <= bus.b;
                        brw_r    <= bus.bin;
                        res_sh_r <= {WIDTH{1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= ST_SHIFT;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_sh_r   <= a_sh_r >> 1'b1;
                    b_sh_r   <= b_sh_r >> 1'b1;
                    res_sh_r <= res_nxt_s;
                    brw_r    <= cout_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        diff_r  <= res_nxt_s;
                        bout_r  <= cout_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;

endmodule
